// File: rtl/operand_pkg.sv
// Shared types for the operand sequencer: the buffered operand pair and the presentation FSM states.
package operand_pkg;

    // Widest operand any instance may use; narrower instances zero-extend into the pair record.
    localparam int OPERAND_MAX_WIDTH = 32;

    typedef struct packed {
        logic [OPERAND_MAX_WIDTH-1:0] a;
        logic [OPERAND_MAX_WIDTH-1:0] b;
    } operand_pair_t;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } seq_state_e;

endpackage

// File: rtl/operand_sequencer_if.sv
// Upstream pair handshake plus downstream operand presentation bus of the operand sequencer.
interface operand_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) ();
    logic                         in_valid;
    logic                         in_ready;
    logic [WIDTH-1:0]             in_a;
    logic [WIDTH-1:0]             in_b;
    logic [WIDTH-1:0]             a_out;
    logic [WIDTH-1:0]             b_out;
    logic                         op_valid;
    logic                         res_strobe;
    logic [$clog2(DEPTH+1)-1:0]   count;

    modport master (
        output in_valid, in_a, in_b,
        input  in_ready, a_out, b_out, op_valid, res_strobe, count
    );

    modport slave (
        input  in_valid, in_a, in_b,
        output in_ready, a_out, b_out, op_valid, res_strobe, count
    );
endinterface

// File: rtl/operand_fifo.sv
// Operand-pair FIFO: array storage with wrapping pointers and an occupancy counter.
module operand_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH+1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [2*WIDTH-1:0] wr_data,
    output logic [2*WIDTH-1:0] rd_data,
    output logic [CW-1:0]      count,
    output logic               full,
    output logic               empty
);
    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr_reg;
    logic [AW-1:0]      rd_ptr_reg;
    logic [CW-1:0]      count_reg;
    logic [CW-1:0]      count_next;
    logic               push_ok;
    logic               pop_ok;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign count   = count_reg;

    // Head is read combinationally; the sequencer registers it into its output stage.
    assign rd_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_comb begin
        count_next = count_reg;
        if (push_ok && !pop_ok) begin
            count_next = count_reg + CW'(1);
        end else if (!push_ok && pop_ok) begin
            count_next = count_reg - CW'(1);
        end
    end

    // DEPTH is a power of two, so pointer increments wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/operand_sequencer.sv
// Buffers operand pairs and presents each to a downstream arithmetic stage for HOLD cycles,
// pulsing res_strobe in the last cycle so the stage's result can be sampled.
module operand_sequencer
    import operand_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int HOLD  = 2
) (
    input  logic                clk,
    input  logic                rst,
    operand_sequencer_if.slave  bus
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    localparam logic [0:0] ST_IDLE    = IDLE;
    localparam logic [0:0] ST_PRESENT = PRESENT;

    logic [0:0]         state_reg;
    logic [0:0]         state_next;
    logic [HW-1:0]      hold_reg;
    logic [HW-1:0]      hold_next;
    operand_pair_t      pair_reg;
    operand_pair_t      pair_next;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic               last;
    logic [2*WIDTH-1:0] head;
    logic [CW-1:0]      count;
    logic               unused_pad;

    operand_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data ({bus.in_a, bus.in_b}),
        .rd_data (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    // Gated by rst so nothing is offered upstream while reset is held.
    assign bus.in_ready = rst && !full;
    assign push         = bus.in_valid && bus.in_ready;
    assign last         = (hold_reg == HW'(HOLD-1));

    // empty reflects the registered count, so a same-edge push into an empty buffer is not yet poppable.
    always_comb begin
        state_next = state_reg;
        hold_next  = hold_reg;
        pair_next  = pair_reg;
        pop        = 1'b0;
        if (state_reg == ST_IDLE) begin
            if (!empty) begin
                pop        = 1'b1;
                state_next = ST_PRESENT;
                hold_next  = '0;
                pair_next.a = OPERAND_MAX_WIDTH'(head[2*WIDTH-1:WIDTH]);
                pair_next.b = OPERAND_MAX_WIDTH'(head[WIDTH-1:0]);
            end
        end else begin
            if (!last) begin
                hold_next = hold_reg + 1'b1;
            end else begin
                hold_next = '0;
                if (!empty) begin
                    pop         = 1'b1;
                    pair_next.a = OPERAND_MAX_WIDTH'(head[2*WIDTH-1:WIDTH]);
                    pair_next.b = OPERAND_MAX_WIDTH'(head[WIDTH-1:0]);
                end else begin
                    state_next = ST_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            hold_reg  <= '0;
            pair_reg  <= '0;
        end else begin
            state_reg <= state_next;
            hold_reg  <= hold_next;
            pair_reg  <= pair_next;
        end
    end

    assign bus.a_out      = pair_reg.a[WIDTH-1:0];
    assign bus.b_out      = pair_reg.b[WIDTH-1:0];
    assign bus.op_valid   = (state_reg == ST_PRESENT);
    assign bus.res_strobe = (state_reg == ST_PRESENT) && last;
    assign bus.count      = count;

    // Upper bits of the shared pair record stay zero when WIDTH is below the package maximum.
    assign unused_pad = ^pair_reg;

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer: a HOLD=2 and a HOLD=1 instance driven from a vector table
// plus hand-written fill/drain and mid-presentation reset sequences.
module tb_operand_sequencer;
    import operand_pkg::*;

    localparam int W  = 8;
    localparam int D  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    operand_sequencer_if #(.WIDTH(W), .DEPTH(D)) bus2 ();
    operand_sequencer_if #(.WIDTH(W), .DEPTH(D)) bus1 ();

    operand_sequencer #(.WIDTH(W), .DEPTH(D), .HOLD(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    operand_sequencer #(.WIDTH(W), .DEPTH(D), .HOLD(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    typedef struct {
        int         grp;
        bit         sel1;
        bit         v;
        logic [7:0] a;
        logic [7:0] b;
        bit         ready;
        bit         opv;
        bit         str;
        logic [7:0] ea;
        logic [7:0] eb;
        logic [2:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int grp, input bit sel1, input bit v, input int a, input int b,
                                input bit ready, input bit opv, input bit str,
                                input int ea, input int eb, input int cnt);
        vec_t r;
        r.grp = grp; r.sel1 = sel1; r.v = v; r.a = 8'(a); r.b = 8'(b);
        r.ready = ready; r.opv = opv; r.str = str;
        r.ea = 8'(ea); r.eb = 8'(eb); r.cnt = 3'(cnt);
        return r;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_a"},     32'(bus2.a_out), 0);
        check({tag, "_b"},     32'(bus2.b_out), 0);
        check({tag, "_opv"},   32'(bus2.op_valid), 0);
        check({tag, "_str"},   32'(bus2.res_strobe), 0);
        check({tag, "_cnt"},   32'(bus2.count), 0);
        check({tag, "_ready"}, 32'(bus2.in_ready), 0);
    endtask

    initial begin
        vec_t       vv;
        logic       rdy, ov, st;
        logic [7:0] oa, ob;
        logic [2:0] oc;
        int         strobes[3];
        logic [7:0] pa[8];
        logic [7:0] pb[8];
        int         idx_push, seen, extra;
        bit         saw_full;
        logic [7:0] ra[4];
        logic [7:0] rb[4];

        bus2.in_valid = 1'b0; bus2.in_a = '0; bus2.in_b = '0;
        bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0;
        for (int i = 0; i < 3; i++) strobes[i] = 0;

        // Single pair on HOLD=2
        vecs.push_back(mk(0, 0, 1,   5,   7, 1, 0, 0,   0,   0, 0));
        vecs.push_back(mk(0, 0, 0,   0,   0, 1, 0, 0,   0,   0, 1));
        vecs.push_back(mk(0, 0, 0,   0,   0, 1, 1, 0,   5,   7, 0));
        vecs.push_back(mk(0, 0, 0,   0,   0, 1, 1, 1,   5,   7, 0));
        vecs.push_back(mk(0, 0, 0,   0,   0, 1, 0, 0,   5,   7, 0));
        // Back-to-back burst; the fourth push coincides with a pop at count 2
        vecs.push_back(mk(1, 0, 1,  10,  20, 1, 0, 0,   5,   7, 0));
        vecs.push_back(mk(1, 0, 1, 100,  50, 1, 0, 0,   5,   7, 1));
        vecs.push_back(mk(1, 0, 1,   0,   0, 1, 1, 0,  10,  20, 1));
        vecs.push_back(mk(1, 0, 1, 255, 255, 1, 1, 1,  10,  20, 2));
        vecs.push_back(mk(1, 0, 0,   0,   0, 1, 1, 0, 100,  50, 2));
        vecs.push_back(mk(1, 0, 0,   0,   0, 1, 1, 1, 100,  50, 2));
        vecs.push_back(mk(1, 0, 0,   0,   0, 1, 1, 0,   0,   0, 1));
        vecs.push_back(mk(1, 0, 0,   0,   0, 1, 1, 1,   0,   0, 1));
        vecs.push_back(mk(1, 0, 0,   0,   0, 1, 1, 0, 255, 255, 0));
        vecs.push_back(mk(1, 0, 0,   0,   0, 1, 1, 1, 255, 255, 0));
        vecs.push_back(mk(1, 0, 0,   0,   0, 1, 0, 0, 255, 255, 0));
        // HOLD=1 instance: three pairs, continuous presentation
        vecs.push_back(mk(2, 1, 1,   1,   2, 1, 0, 0,   0,   0, 0));
        vecs.push_back(mk(2, 1, 1,   3,   4, 1, 0, 0,   0,   0, 1));
        vecs.push_back(mk(2, 1, 1,   5,   6, 1, 1, 1,   1,   2, 1));
        vecs.push_back(mk(2, 1, 0,   0,   0, 1, 1, 1,   3,   4, 1));
        vecs.push_back(mk(2, 1, 0,   0,   0, 1, 1, 1,   5,   6, 0));
        vecs.push_back(mk(2, 1, 0,   0,   0, 1, 0, 0,   5,   6, 0));

        // Reset state while rst is held low
        @(negedge clk);
        @(negedge clk);
        #1;
        check_zero("reset");
        check("reset_h1_opv",   32'(bus1.op_valid), 0);
        check("reset_h1_ready", 32'(bus1.in_ready), 0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            vv = vecs[i];
            @(negedge clk);
            bus2.in_valid = !vv.sel1 && vv.v; bus2.in_a = vv.a; bus2.in_b = vv.b;
            bus1.in_valid =  vv.sel1 && vv.v; bus1.in_a = vv.a; bus1.in_b = vv.b;
            #1;
            if (vv.sel1) begin
                rdy = bus1.in_ready; ov = bus1.op_valid; st = bus1.res_strobe;
                oa = bus1.a_out; ob = bus1.b_out; oc = bus1.count;
            end else begin
                rdy = bus2.in_ready; ov = bus2.op_valid; st = bus2.res_strobe;
                oa = bus2.a_out; ob = bus2.b_out; oc = bus2.count;
            end
            $display("vec %0d grp=%0d in=%0d(%0d,%0d) ready=%0d opv=%0d out=(%0d,%0d) str=%0d cnt=%0d",
                     i, vv.grp, vv.v, vv.a, vv.b, rdy, ov, oa, ob, st, oc);
            check($sformatf("v%0d_ready", i), 32'(rdy), 32'(vv.ready));
            check($sformatf("v%0d_opv", i),   32'(ov),  32'(vv.opv));
            check($sformatf("v%0d_str", i),   32'(st),  32'(vv.str));
            check($sformatf("v%0d_a", i),     32'(oa),  32'(vv.ea));
            check($sformatf("v%0d_b", i),     32'(ob),  32'(vv.eb));
            check($sformatf("v%0d_cnt", i),   32'(oc),  32'(vv.cnt));
            if (st) strobes[vv.grp]++;
        end
        check("single_strobes", 32'(strobes[0]), 1);
        check("burst_strobes",  32'(strobes[1]), 4);
        check("hold1_strobes",  32'(strobes[2]), 3);

        // Fill against a one-pair-per-two-cycles drain with in_valid held high
        for (int k = 0; k < 8; k++) begin
            pa[k] = 8'(k * 16 + 1);
            pb[k] = 8'(250 - k * 3);
        end
        idx_push = 0; seen = 0; saw_full = 1'b0;
        for (int cyc = 0; cyc < 60 && seen < 8; cyc++) begin
            @(negedge clk);
            bus1.in_valid = 1'b0;
            bus2.in_valid = (idx_push < 8);
            bus2.in_a = pa[idx_push % 8];
            bus2.in_b = pb[idx_push % 8];
            #1;
            $display("fill cyc=%0d pushed=%0d seen=%0d ready=%0d cnt=%0d str=%0d",
                     cyc, idx_push, seen, bus2.in_ready, bus2.count, bus2.res_strobe);
            if (bus2.count == 3'(D)) begin
                saw_full = 1'b1;
                check("full_ready", 32'(bus2.in_ready), 0);
            end
            if (bus2.res_strobe) begin
                check($sformatf("fill_a%0d", seen), 32'(bus2.a_out), 32'(pa[seen]));
                check($sformatf("fill_b%0d", seen), 32'(bus2.b_out), 32'(pb[seen]));
                seen++;
            end
            if (bus2.in_valid && bus2.in_ready) idx_push++;
        end
        check("fill_seen",     32'(seen), 8);
        check("fill_pushed",   32'(idx_push), 8);
        check("fill_saw_full", 32'(saw_full), 1);
        extra = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            bus2.in_valid = 1'b0;
            #1;
            if (bus2.res_strobe) extra++;
        end
        check("fill_no_dup",   32'(extra), 0);
        check("fill_cnt_end",  32'(bus2.count), 0);

        // Reset during the first presentation cycle of (100,50) with two pairs buffered
        ra[0] = 8'd10;  rb[0] = 8'd20;
        ra[1] = 8'd100; rb[1] = 8'd50;
        ra[2] = 8'd0;   rb[2] = 8'd0;
        ra[3] = 8'd255; rb[3] = 8'd255;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus2.in_valid = 1'b1; bus2.in_a = ra[k]; bus2.in_b = rb[k];
            $display("rst_seq push (%0d,%0d)", ra[k], rb[k]);
        end
        @(negedge clk);
        bus2.in_valid = 1'b0;
        #1;
        check("rst_pre_a",   32'(bus2.a_out), 100);
        check("rst_pre_cnt", 32'(bus2.count), 2);
        check("rst_pre_str", 32'(bus2.res_strobe), 0);
        rst = 1'b0;
        #1;
        $display("rst_seq reset asserted mid-presentation");
        check_zero("rst_now");
        @(negedge clk);
        #1;
        check_zero("rst_held");
        @(negedge clk);
        rst = 1'b1;
        bus2.in_valid = 1'b1; bus2.in_a = 8'd42; bus2.in_b = 8'd43;
        #1;
        $display("rst_seq released, push (42,43)");
        check("rel_ready", 32'(bus2.in_ready), 1);
        check("rel_opv",   32'(bus2.op_valid), 0);
        @(negedge clk);
        bus2.in_valid = 1'b0;
        #1;
        check("rel_c1_opv", 32'(bus2.op_valid), 0);
        check("rel_c1_cnt", 32'(bus2.count), 1);
        @(negedge clk);
        #1;
        check("rel_c2_opv", 32'(bus2.op_valid), 1);
        check("rel_c2_a",   32'(bus2.a_out), 42);
        check("rel_c2_b",   32'(bus2.b_out), 43);
        check("rel_c2_str", 32'(bus2.res_strobe), 0);
        @(negedge clk);
        #1;
        check("rel_c3_opv", 32'(bus2.op_valid), 1);
        check("rel_c3_str", 32'(bus2.res_strobe), 1);
        @(negedge clk);
        #1;
        check("rel_c4_opv", 32'(bus2.op_valid), 0);
        check("rel_c4_a",   32'(bus2.a_out), 42);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
